// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants, types and helpers for the multi-port register file.
//   XLEN / NREGS  : default data width and register count
//   reg_idx_t     : register index type for the default configuration
//   xlen_t        : register data type for the default configuration
//   popcount      : population count used for the pending-write counter
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    typedef logic [4:0]      reg_idx_t;
    typedef logic [XLEN-1:0] xlen_t;

    // Widest busy vector the popcount helper accepts; callers zero-pad.
    localparam int POP_MAX_W = 1024;
    localparam int POP_CNT_W = $clog2(POP_MAX_W) + 1;

    function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] vec);
        logic [POP_CNT_W-1:0] cnt;
        cnt = {POP_CNT_W{1'b0}};
        for (int i = 0; i < POP_MAX_W; i++) begin
            cnt = cnt + POP_CNT_W'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Pending-write scoreboard: one busy bit per register (bit 0 tied to zero)
// plus a registered count of pending registers.
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_en       : write enables from the writeback ports (clear busy)
//   wr_idx      : write indices, port j at [j*IDX_W +: IDX_W]
//   sb_set      : mark sb_idx pending (issue stage)
//   sb_idx      : index to mark pending
//   busy        : registered busy bits, one per register
//   pend_cnt    : registered number of busy registers
// A set and a clear of the same register on one edge leave it busy: the set
// belongs to a newer producer than the write that is retiring.
// ---------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int DEPTH  = NREGS,
    parameter  int NUM_WR = 1,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_WR-1:0]       wr_en,
    input  logic [NUM_WR*IDX_W-1:0] wr_idx,
    input  logic                    sb_set,
    input  logic [IDX_W-1:0]        sb_idx,
    output logic [DEPTH-1:0]        busy,
    output logic [IDX_W:0]          pend_cnt
);

    if (DEPTH > POP_MAX_W) begin : g_bad_depth
        $error("regfile_scoreboard: DEPTH exceeds popcount helper width");
    end

    logic [DEPTH-1:0]     r_busy;
    logic [IDX_W:0]       r_pend_cnt;
    logic [DEPTH-1:1]     w_clr;
    logic [DEPTH-1:1]     w_set;
    logic [DEPTH-1:0]     w_busy_nxt;
    logic [POP_MAX_W-1:0] w_busy_pad;

    // Next busy state: per register, set dominates clear, otherwise hold.
    always_comb begin
        w_clr      = '0;
        w_set      = '0;
        w_busy_nxt = '0;
        w_busy_pad = '0;
        for (int k = 1; k < DEPTH; k++) begin
            for (int j = 0; j < NUM_WR; j++) begin
                w_clr[k] = w_clr[k] |
                           (wr_en[j] & (wr_idx[j*IDX_W +: IDX_W] == IDX_W'(k)));
            end
            w_set[k]      = sb_set & (sb_idx == IDX_W'(k));
            w_busy_nxt[k] = w_set[k] | (r_busy[k] & ~w_clr[k]);
        end
        w_busy_nxt[0]            = 1'b0;
        w_busy_pad[DEPTH-1:1]    = w_busy_nxt[DEPTH-1:1];
    end

    // Busy bits and their count update together so they never disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_pend_cnt <= (IDX_W+1)'(popcount(w_busy_pad));
        end
    end

    assign busy     = r_busy;
    assign pend_cnt = r_pend_cnt;

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port integer register file with a pending-write
// scoreboard. Register 0 reads as zero and is never written or marked busy.
//   clk, rst_n : clock, asynchronous active-low reset
//   rd_idx     : read indices, port i at [i*IDX_W +: IDX_W]
//   rd_data    : read data, port i at [i*WIDTH +: WIDTH] (combinational)
//   rd_busy    : 1 = register addressed by port i has a pending write
//   wr_en      : write enables, one per write port
//   wr_idx     : write indices, port j at [j*IDX_W +: IDX_W]
//   wr_data    : write data, port j at [j*WIDTH +: WIDTH]
//   sb_set     : mark sb_idx pending
//   sb_idx     : scoreboard set index
//   pend_cnt   : number of registers currently pending
// Optional feature, macro REGFILE_BYPASS_EN: reads that hit a same-cycle
// write return the write data (highest write port wins) and report not busy
// unless sb_set targets the same register in that cycle.
// ---------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int WIDTH  = XLEN,
    parameter  int DEPTH  = NREGS,
    parameter  int NUM_RD = 2,
    parameter  int NUM_WR = 1,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_RD*IDX_W-1:0] rd_idx,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_busy,
    input  logic [NUM_WR-1:0]       wr_en,
    input  logic [NUM_WR*IDX_W-1:0] wr_idx,
    input  logic [NUM_WR*WIDTH-1:0] wr_data,
    input  logic                    sb_set,
    input  logic [IDX_W-1:0]        sb_idx,
    output logic [IDX_W:0]          pend_cnt
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("regfile_mp: DEPTH must be a power of two and at least 2");
    end
    if (NUM_RD < 1 || NUM_RD > 6) begin : g_bad_nrd
        $error("regfile_mp: NUM_RD must be in 1..6");
    end
    if (NUM_WR < 1 || NUM_WR > 3) begin : g_bad_nwr
        $error("regfile_mp: NUM_WR must be in 1..3");
    end

    logic [WIDTH-1:0]        r_mem [DEPTH];
    logic [DEPTH-1:0]        w_sb_busy;
    logic [NUM_RD*WIDTH-1:0] w_rd_data;
    logic [NUM_RD-1:0]       w_rd_busy;
    logic [IDX_W-1:0]        w_ridx;
    logic [WIDTH-1:0]        w_data;
    logic                    w_busy;
`ifdef REGFILE_BYPASS_EN
    logic                    w_hit;
`endif

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .sb_set   (sb_set),
        .sb_idx   (sb_idx),
        .busy     (w_sb_busy),
        .pend_cnt (pend_cnt)
    );

    // Data array: later (higher-numbered) ports are applied last and win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_idx[j*IDX_W +: IDX_W] != {IDX_W{1'b0}})) begin
                    r_mem[wr_idx[j*IDX_W +: IDX_W]] <= wr_data[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Read muxes, with optional same-cycle write bypass.
    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        w_ridx    = '0;
        w_data    = '0;
        w_busy    = 1'b0;
`ifdef REGFILE_BYPASS_EN
        w_hit     = 1'b0;
`endif
        for (int i = 0; i < NUM_RD; i++) begin
            w_ridx = rd_idx[i*IDX_W +: IDX_W];
            w_data = (w_ridx != {IDX_W{1'b0}}) ? r_mem[w_ridx] : {WIDTH{1'b0}};
            w_busy = w_sb_busy[w_ridx];
`ifdef REGFILE_BYPASS_EN
            // Bypass is suppressed under reset so reads stay zero while the
            // array is being cleared, whatever the writeback ports present.
            for (int j = 0; j < NUM_WR; j++) begin
                w_hit  = rst_n & wr_en[j] &
                         (wr_idx[j*IDX_W +: IDX_W] == w_ridx) &
                         (w_ridx != {IDX_W{1'b0}});
                w_data = w_hit ? wr_data[j*WIDTH +: WIDTH] : w_data;
                w_busy = w_hit ? (sb_set & (sb_idx == w_ridx)) : w_busy;
            end
`endif
            w_rd_data[i*WIDTH +: WIDTH] = w_data;
            w_rd_busy[i]                = w_busy;
        end
    end

    assign rd_data = w_rd_data;
    assign rd_busy = w_rd_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
// Directed self-checking bench for regfile_mp (4 read ports, 2 write ports),
// followed by a short reference-model run with random traffic. Expected
// values follow the bypass behaviour selected by REGFILE_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int NR = 4;
    localparam int NW = 2;
    localparam int IW = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [NR*IW-1:0] rd_idx;
    logic [NR*W-1:0]  rd_data;
    logic [NR-1:0]    rd_busy;
    logic [NW-1:0]    wr_en;
    logic [NW*IW-1:0] wr_idx;
    logic [NW*W-1:0]  wr_data;
    logic             sb_set;
    logic [IW-1:0]    sb_idx;
    logic [IW:0]      pend_cnt;

    int n_checks;
    int n_errors;

    logic [W-1:0] m_mem  [D];
    logic         m_busy [D];
    int           m_pend;

    regfile_mp #(
        .WIDTH  (W),
        .DEPTH  (D),
        .NUM_RD (NR),
        .NUM_WR (NW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .sb_set   (sb_set),
        .sb_idx   (sb_idx),
        .pend_cnt (pend_cnt)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en   = '0;
        wr_idx  = '0;
        wr_data = '0;
        sb_set  = 1'b0;
        sb_idx  = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic wr(input int port, input logic [IW-1:0] idx, input logic [W-1:0] d);
        wr_en[port]            = 1'b1;
        wr_idx[port*IW +: IW]  = idx;
        wr_data[port*W +: W]   = d;
    endtask

    task automatic sbs(input logic [IW-1:0] idx);
        sb_set = 1'b1;
        sb_idx = idx;
    endtask

    task automatic expect_reg(input string tag, input logic [IW-1:0] idx,
                              input logic [W-1:0] d, input logic b);
        for (int p = 0; p < NR; p++) rd_idx[p*IW +: IW] = idx;
        #1;
        for (int p = 0; p < NR; p++) begin
            check({tag, "_data"}, 64'(rd_data[p*W +: W]), 64'(d));
            check({tag, "_busy"}, 64'(rd_busy[p]), 64'(b));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        rd_idx   = '0;
        idle();

        // 1. Reset while writes and a scoreboard set are being presented.
        wr(0, 5'd5, 32'h1234_5678);
        wr(1, 5'd3, 32'hCAFE_F00D);
        sbs(5'd9);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < D; k++) expect_reg("reset", IW'(k), 32'h0, 1'b0);
        check("reset_pend", 64'(pend_cnt), 64'd0);
        idle();
        rst_n = 1'b1;
        cycle();
        wr(0, 5'd5, 32'hDEAD_BEEF);
        cycle();
        expect_reg("x5_write", 5'd5, 32'hDEAD_BEEF, 1'b0);

        // 2. Register 0 ignores writes and scoreboard sets.
        wr(0, 5'd0, 32'hFFFF_FFFF);
        sbs(5'd0);
        expect_reg("x0_same", 5'd0, 32'h0, 1'b0);
        cycle();
        expect_reg("x0_after", 5'd0, 32'h0, 1'b0);
        check("x0_pend", 64'(pend_cnt), 64'd0);

        // 3. Write-port conflicts and independent writes.
        wr(0, 5'd7, 32'h11);
        wr(1, 5'd7, 32'h22);
        expect_reg("x7_same", 5'd7, BYP ? 32'h22 : 32'h0, 1'b0);
        cycle();
        expect_reg("x7_conflict", 5'd7, 32'h22, 1'b0);
        wr(0, 5'd3, 32'hA);
        wr(1, 5'd4, 32'hB);
        cycle();
        expect_reg("x3_write", 5'd3, 32'hA, 1'b0);
        expect_reg("x4_write", 5'd4, 32'hB, 1'b0);

        // 4. Scoreboard set, clear, set-beats-clear, fill.
        sbs(5'd9);
        expect_reg("x9_pre", 5'd9, 32'h0, 1'b0);
        cycle();
        expect_reg("x9_set", 5'd9, 32'h0, 1'b1);
        check("x9_set_pend", 64'(pend_cnt), 64'd1);
        wr(0, 5'd9, 32'h99);
        expect_reg("x9_wr_same", 5'd9, BYP ? 32'h99 : 32'h0, BYP ? 1'b0 : 1'b1);
        cycle();
        expect_reg("x9_clr", 5'd9, 32'h99, 1'b0);
        check("x9_clr_pend", 64'(pend_cnt), 64'd0);
        wr(1, 5'd9, 32'h77);
        sbs(5'd9);
        expect_reg("x9_setclr_same", 5'd9, BYP ? 32'h77 : 32'h99, BYP ? 1'b1 : 1'b0);
        cycle();
        expect_reg("x9_setclr", 5'd9, 32'h77, 1'b1);
        check("x9_setclr_pend", 64'(pend_cnt), 64'd1);
        for (int k = 1; k < D; k++) begin
            sbs(IW'(k));
            cycle();
            check("fill_pend", 64'(pend_cnt), (k < 9) ? 64'(k + 1) : 64'(k));
        end
        check("full_pend", 64'(pend_cnt), 64'd31);
        expect_reg("full_x0", 5'd0, 32'h0, 1'b0);
        expect_reg("full_x31", 5'd31, 32'h0, 1'b1);
        sbs(5'd9);
        cycle();
        check("reset_busy_pend", 64'(pend_cnt), 64'd31);
        wr(0, 5'd9, 32'h5A);
        cycle();
        expect_reg("x9_single_clr", 5'd9, 32'h5A, 1'b0);
        check("single_clr_pend", 64'(pend_cnt), 64'd30);

        // Reset in the middle of traffic takes effect immediately.
        wr(0, 5'd7, 32'h123);
        sbs(5'd10);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_pend", 64'(pend_cnt), 64'd0);
        expect_reg("midrst_x7", 5'd7, 32'h0, 1'b0);
        expect_reg("midrst_x31", 5'd31, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        idle();
        rst_n = 1'b1;
        #1;
        expect_reg("postrst_x7", 5'd7, 32'h0, 1'b0);
        check("postrst_pend", 64'(pend_cnt), 64'd0);

        // 5. Same-cycle read of a register being written.
        wr(0, 5'd12, 32'h33);
        cycle();
        wr(0, 5'd12, 32'h55);
        expect_reg("byp_same", 5'd12, BYP ? 32'h55 : 32'h33, 1'b0);
        cycle();
        expect_reg("byp_next", 5'd12, 32'h55, 1'b0);
        wr(1, 5'd12, 32'h66);
        sbs(5'd12);
        expect_reg("byp_sb_same", 5'd12, BYP ? 32'h66 : 32'h55, BYP ? 1'b1 : 1'b0);
        cycle();
        expect_reg("byp_sb_next", 5'd12, 32'h66, 1'b1);

        // 6. Random traffic against a reference model, from a fresh reset.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < D; k++) begin
            m_mem[k]  = '0;
            m_busy[k] = 1'b0;
        end
        m_pend = 0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 400; c++) begin
            logic [W-1:0]  ed;
            logic          eb;
            logic [IW-1:0] ri;
            idle();
            for (int j = 0; j < NW; j++) begin
                wr_en[j]          = 1'($urandom_range(0, 1));
                wr_idx[j*IW +: IW] = IW'($urandom_range(0, (c % 2 == 0) ? 7 : 31));
                wr_data[j*W +: W]  = $urandom;
            end
            sb_set = 1'($urandom_range(0, 1));
            sb_idx = IW'($urandom_range(0, 7));
            for (int p = 0; p < NR; p++) rd_idx[p*IW +: IW] = IW'($urandom_range(0, 7));
            #1;
            for (int p = 0; p < NR; p++) begin
                ri = rd_idx[p*IW +: IW];
                ed = (ri == 5'd0) ? 32'h0 : m_mem[ri];
                eb = (ri == 5'd0) ? 1'b0 : m_busy[ri];
                for (int j = 0; j < NW; j++) begin
                    if (BYP && wr_en[j] && wr_idx[j*IW +: IW] == ri && ri != 5'd0) begin
                        ed = wr_data[j*W +: W];
                        eb = sb_set && (sb_idx == ri);
                    end
                end
                check("rand_data", 64'(rd_data[p*W +: W]), 64'(ed));
                check("rand_busy", 64'(rd_busy[p]), 64'(eb));
            end
            check("rand_pend", 64'(pend_cnt), 64'(m_pend));
            @(posedge clk);
            for (int j = 0; j < NW; j++) begin
                if (wr_en[j] && wr_idx[j*IW +: IW] != 5'd0) begin
                    m_mem[wr_idx[j*IW +: IW]]  = wr_data[j*W +: W];
                    m_busy[wr_idx[j*IW +: IW]] = 1'b0;
                end
            end
            if (sb_set && sb_idx != 5'd0) m_busy[sb_idx] = 1'b1;
            m_pend = 0;
            for (int k = 1; k < D; k++) m_pend += int'(m_busy[k]);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
